// File: rtl/dram_uart_dump.sv
// dram_uart_dump
//   Reads a contiguous region of data memory through its external read port
//   and sends each byte on a UART TX line (8N1, LSB first). The dump starts on
//   a start request, and only from IDLE.
//
// Ports
//   clk       in   1   clock; all state changes on posedge
//   reset     in   1   synchronous, active-high reset
//   start     in   1   begin a dump; ignored unless IDLE
//   ext_addr  out 19   data memory extAddr (BASE_ADDR + byte index)
//   ext_data  in   8   data memory ext_d_out; valid the cycle after ext_addr changes
//   tx        out  1   UART serial output, idle high
//   busy      out  1   dump in progress (drops on the same edge that raises done)
//   done      out  1   one-cycle pulse after the last stop bit
module dram_uart_dump #(
    parameter logic [18:0] BASE_ADDR    = 19'd0,
    parameter int          LEN          = 16384,
    parameter int          CLKS_PER_BIT = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [18:0] ext_addr,
    input  logic [7:0]  ext_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int IDX_W  = (LEN > 1) ? $clog2(LEN) : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE, FETCH, LOAD, START, DATA, STOP, DONE
    } state_t;

    state_t             state, next_state;
    logic [IDX_W-1:0]   idx;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [2:0]         bit_cnt;
    logic [7:0]         shift;
    logic               baud_wrap;
    logic               last_byte;

    assign baud_wrap = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign last_byte = (idx == IDX_W'(LEN - 1));

    // NOTE: non-blocking assignments in every clocked block, so all registers
    // update from the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: next_state gets its default before the case; any path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = FETCH;
            FETCH:   next_state = LOAD;
            LOAD:    next_state = START;
            START:   if (baud_wrap) next_state = DATA;
            DATA:    if (baud_wrap && bit_cnt == 3'd7) next_state = STOP;
            STOP:    if (baud_wrap) next_state = last_byte ? DONE : FETCH;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Datapath and registered outputs. tx is loaded one edge ahead of the bit
    // it shows, so the line changes exactly on the state-transition edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            ext_addr <= BASE_ADDR;
            idx      <= '0;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
        end else begin
            // busy stays up through DONE and falls when done rises.
            busy <= (next_state != IDLE);
            done <= (state == DONE);

            if (state == START || state == DATA || state == STOP)
                baud_cnt <= baud_wrap ? '0 : baud_cnt + BAUD_W'(1);
            else
                baud_cnt <= '0;

            case (state)
                IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        ext_addr <= BASE_ADDR;
                    end
                end
                LOAD: begin
                    shift   <= ext_data;
                    tx      <= 1'b0;
                    bit_cnt <= '0;
                end
                START: begin
                    if (baud_wrap) tx <= shift[0];
                end
                DATA: begin
                    if (baud_wrap) begin
                        shift   <= shift >> 1;
                        bit_cnt <= bit_cnt + 3'd1;
                        tx      <= (bit_cnt == 3'd7) ? 1'b1 : shift[1];
                    end
                end
                STOP: begin
                    // Parameter range guarantees BASE_ADDR+idx never wraps.
                    if (baud_wrap && !last_byte) begin
                        idx      <= idx + IDX_W'(1);
                        ext_addr <= BASE_ADDR + 19'(idx) + 19'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dram_uart_dump.sv
module tb_dram_uart_dump;

    localparam int CPB = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    int   sel = 0;

    always #5 clk = ~clk;

    logic [7:0] mem [0:16910];

    logic [18:0] addr_a, addr_b, addr_c;
    logic [7:0]  data_a, data_b, data_c;
    logic        tx_a, tx_b, tx_c, busy_a, busy_b, busy_c, done_a, done_b, done_c;

    always @(posedge clk) begin
        data_a <= mem[addr_a];
        data_b <= mem[addr_b];
        data_c <= mem[addr_c];
    end

    dram_uart_dump #(.BASE_ADDR(19'd5), .LEN(1), .CLKS_PER_BIT(CPB)) dut_a (
        .clk(clk), .reset(reset), .start(start && sel == 0), .ext_addr(addr_a),
        .ext_data(data_a), .tx(tx_a), .busy(busy_a), .done(done_a));
    dram_uart_dump #(.BASE_ADDR(19'd100), .LEN(3), .CLKS_PER_BIT(CPB)) dut_b (
        .clk(clk), .reset(reset), .start(start && sel == 1), .ext_addr(addr_b),
        .ext_data(data_b), .tx(tx_b), .busy(busy_b), .done(done_b));
    dram_uart_dump #(.BASE_ADDR(19'd16909), .LEN(2), .CLKS_PER_BIT(CPB)) dut_c (
        .clk(clk), .reset(reset), .start(start && sel == 2), .ext_addr(addr_c),
        .ext_data(data_c), .tx(tx_c), .busy(busy_c), .done(done_c));

    logic        tx_m, busy_m, done_m;
    logic [18:0] addr_m;
    always_comb begin
        tx_m = tx_a; busy_m = busy_a; done_m = done_a; addr_m = addr_a;
        if (sel == 1) begin tx_m = tx_b; busy_m = busy_b; done_m = done_b; addr_m = addr_b; end
        if (sel == 2) begin tx_m = tx_c; busy_m = busy_c; done_m = done_c; addr_m = addr_c; end
    end

    typedef struct { logic [18:0] addr; logic [7:0] data; } exp_t;
    exp_t sbq[$];

    int total = 0;
    int bad = 0;
    int addr_over = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) if (sel == 2 && addr_c > 19'd16910) addr_over++;

    // Monitor: decode UART frames from the selected DUT, compare against scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_m === 1'b0 && !reset) begin
                automatic logic        aborted = 1'b0;
                automatic logic [7:0]  got = '0;
                automatic logic [18:0] faddr = addr_m;
                automatic logic        sbit, pbit;
                automatic exp_t        e;
                repeat (CPB / 2) begin @(negedge clk); if (reset) aborted = 1'b1; end
                sbit = tx_m;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) begin @(negedge clk); if (reset) aborted = 1'b1; end
                    got[i] = tx_m;
                end
                repeat (CPB) begin @(negedge clk); if (reset) aborted = 1'b1; end
                pbit = tx_m;
                if (!aborted) begin
                    if (sbq.size() == 0) begin
                        check("unexpected_frame", 32'd1, 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        check("frame_start_bit", {31'd0, sbit}, 32'd0);
                        check("frame_data", {24'd0, got}, {24'd0, e.data});
                        check("frame_stop_bit", {31'd0, pbit}, 32'd1);
                        check("frame_addr", {13'd0, faddr}, {13'd0, e.addr});
                    end
                end
            end
        end
    end

    // Accept a start, then count edges until done; optional start pulses at p1/p2.
    task automatic go_and_wait(input string nm, input int exp_n, input int p1, input int p2);
        int n;
        int busy_bad = 0;
        logic found = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, "_busy_on_accept"}, {31'd0, busy_m}, 32'd1);
        for (n = 1; n <= 3000; n++) begin
            @(posedge clk); #1;
            start = (n == p1 || n == p2);
            if (n == 1) check({nm, "_tx_high_fetch"}, {31'd0, tx_m}, 32'd1);
            if (n == 2) check({nm, "_tx_fall_load"}, {31'd0, tx_m}, 32'd0);
            if (done_m) begin found = 1'b1; break; end
            if (!busy_m) busy_bad++;
        end
        start = 1'b0;
        if (!found) check({nm, "_done_timeout"}, 32'd0, 32'd1);
        else begin
            check({nm, "_done_edge"}, n, exp_n);
            check({nm, "_busy_low_at_done"}, {31'd0, busy_m}, 32'd0);
            check({nm, "_busy_throughout"}, busy_bad, 32'd0);
        end
        @(posedge clk); #1;
        check({nm, "_done_one_cycle"}, {31'd0, done_m}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i <= 16910; i++) mem[i] = 8'h00;
        mem[5] = 8'hA5;
        mem[100] = 8'h00; mem[101] = 8'hFF; mem[102] = 8'h3C;
        mem[16909] = 8'h01; mem[16910] = 8'h80;

        // Reset, with start held high to show reset wins.
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx", {29'd0, tx_a, tx_b, tx_c}, 32'h7);
        check("rst_busy", {29'd0, busy_a, busy_b, busy_c}, 32'h0);
        check("rst_done", {29'd0, done_a, done_b, done_c}, 32'h0);
        check("rst_addr_a", {13'd0, addr_a}, 32'd5);
        check("rst_addr_b", {13'd0, addr_b}, 32'd100);
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // 1: single byte A5 at address 5
        sel = 0;
        sbq.push_back('{19'd5, 8'hA5});
        go_and_wait("s1", 43, -1, -1);
        repeat (5) @(posedge clk);
        #1;

        // 2: three bytes from 100
        sel = 1;
        sbq.push_back('{19'd100, 8'h00});
        sbq.push_back('{19'd101, 8'hFF});
        sbq.push_back('{19'd102, 8'h3C});
        go_and_wait("s2", 127, -1, -1);
        repeat (5) @(posedge clk);
        #1;

        // 3: start pulses during frame 2 and in the DONE cycle are ignored
        sbq.push_back('{19'd100, 8'h00});
        sbq.push_back('{19'd101, 8'hFF});
        sbq.push_back('{19'd102, 8'h3C});
        go_and_wait("s3", 127, 50, 126);
        repeat (60) @(posedge clk);
        #1;
        check("s3_no_retrigger", {31'd0, busy_m}, 32'd0);
        check("s3_sb_empty", sbq.size(), 32'd0);

        // 4: reset in the middle of byte 2 data bits
        sbq.push_back('{19'd100, 8'h00});
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("s4_tx_after_rst", {31'd0, tx_b}, 32'd1);
        check("s4_busy_after_rst", {31'd0, busy_b}, 32'd0);
        check("s4_addr_after_rst", {13'd0, addr_b}, 32'd100);
        repeat (50) @(posedge clk);
        #1;
        check("s4_sb_empty_pre", sbq.size(), 32'd0);
        sbq.push_back('{19'd100, 8'h00});
        sbq.push_back('{19'd101, 8'hFF});
        sbq.push_back('{19'd102, 8'h3C});
        go_and_wait("s4", 127, -1, -1);
        repeat (5) @(posedge clk);
        #1;

        // 5: last valid addresses
        sel = 2;
        sbq.push_back('{19'd16909, 8'h01});
        sbq.push_back('{19'd16910, 8'h80});
        go_and_wait("s5", 85, -1, -1);
        check("s5_addr_in_range", addr_over, 32'd0);
        repeat (5) @(posedge clk);
        #1;

        // 6: start held high for 300 edges; dumps start every 44 edges -> 7 dumps
        sel = 0;
        begin
            int dones = 0;
            int idle_tx_bad = 0;
            for (int i = 0; i < 7; i++) sbq.push_back('{19'd5, 8'hA5});
            start = 1'b1;
            for (int i = 0; i < 300; i++) begin
                @(posedge clk); #1;
                if (done_m) dones++;
                if (!busy_m && !tx_m) idle_tx_bad++;
            end
            start = 1'b0;
            for (int i = 0; i < 100; i++) begin
                @(posedge clk); #1;
                if (done_m) dones++;
            end
            check("s6_dump_count", dones, 32'd7);
            check("s6_tx_idle_high", idle_tx_bad, 32'd0);
        end
        check("final_sb_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
